// File: rtl/lcd_text_reader.sv
// lcd_text_reader
//   Text-mode LCD scan-out engine. Free-running horizontal/vertical
//   counters walk the panel raster. For every visible pixel the engine reads
//   the character cell from VRAM, then the matching glyph row from the font
//   ROM, and finally emits one monochrome pixel. VRAM bit 7 of a cell
//   selects inverse video for that cell.
//
//   Pipeline (one pixel per clock, 3 clocks latency):
//     stage 0 : counters -> VRAM address (combinational, cell = 8x16 pixels)
//     stage 1 : VRAM data -> font address (combinational)
//     stage 2 : font data -> pixel bit select and inversion
//     stage 3 : registered panel outputs
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   v_adb, v_ceb     : VRAM read address and read enable
//   v_dout           : VRAM read data, valid one clock after the address
//   font_addr        : {char[6:0], glyph_row[3:0]}
//   font_data        : glyph row, valid one clock after font_addr, bit 7 = leftmost
//   lcd_de           : data enable, high on visible pixels
//   lcd_hsync/vsync  : active-low syncs, aligned with pixel data
//   lcd_r/g/b        : RGB565 pixel, all ones (white) or all zeros (black)
//   frame_start      : one-clock pulse at the start of vertical blanking

module lcd_text_reader #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int COLS     = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  v_adb,
    output logic        v_ceb,
    input  logic [7:0]  v_dout,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        lcd_de,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]    COLS_A = 10'(COLS);

    // Highest cell address the raster can reach; it has to fit the 10-bit bus.
    localparam int MAX_ADDR = ((V_ACTIVE - 1) / 16) * COLS + (H_ACTIVE - 1) / 8;

    generate
        if (MAX_ADDR > 1023 || COLS > 1023) begin : g_addr_check
            $error("lcd_text_reader: text geometry exceeds the 10-bit VRAM address");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: timing decode and VRAM address
    // ------------------------------------------------------------------
    logic       w_active;
    logic       w_hsync_on;
    logic       w_vsync_on;
    logic [9:0] w_row;
    logic [9:0] w_col;
    logic [9:0] w_row_base;
    logic [9:0] w_addr;
    logic [9:0] r_adb_hold;

    assign w_active   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_hsync_on = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
    assign w_vsync_on = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);

    // Character cells are 8 pixels wide and 16 lines tall.
    assign w_row      = 10'(r_vcnt >> 4);
    assign w_col      = 10'(r_hcnt >> 3);
    assign w_row_base = w_row * COLS_A;
    assign w_addr     = w_row_base + w_col;

    // Outside the visible area the bus keeps the last fetched address so the
    // VRAM address lines stay quiet during blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adb_hold <= '0;
        end else if (w_active) begin
            r_adb_hold <= w_addr;
        end
    end

    // Counters sit at 0/0 during reset, so w_addr is already 0 there; the read
    // enable is gated by reset because that raster position counts as visible.
    assign v_adb = w_active ? w_addr : r_adb_hold;
    assign v_ceb = rst_n & w_active;

    assign frame_start = (r_hcnt == '0) && (r_vcnt == V_ACT);

    // ------------------------------------------------------------------
    // Control delay line: {vsync_on, hsync_on, active}, index = stage.
    // Syncs are carried active-high so a cleared pipeline means "no sync".
    // ------------------------------------------------------------------
    logic [2:0]       w_ctl_s0;
    logic [3:1][2:0]  r_ctl_pipe;

    assign w_ctl_s0 = {w_vsync_on, w_hsync_on, w_active};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl_pipe <= '0;
        end else begin
            r_ctl_pipe <= {r_ctl_pipe[2:1], w_ctl_s0};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: VRAM data -> font address
    // ------------------------------------------------------------------
    logic [2:0] r_hcnt_d1;
    logic [3:0] r_vcnt_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt_d1 <= '0;
            r_vcnt_d1 <= '0;
        end else begin
            r_hcnt_d1 <= r_hcnt[2:0];
            r_vcnt_d1 <= r_vcnt[3:0];
        end
    end

    // Only look up glyphs for visible pixels; keeps the font bus at 0 otherwise.
    assign font_addr = r_ctl_pipe[1][0] ? {v_dout[6:0], r_vcnt_d1} : '0;

    // ------------------------------------------------------------------
    // Stage 2: glyph bit select and inverse video
    // ------------------------------------------------------------------
    logic [2:0] r_hcnt_d2;
    logic       r_inv_d2;
    logic       w_pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt_d2 <= '0;
            r_inv_d2  <= 1'b0;
        end else begin
            r_hcnt_d2 <= r_hcnt_d1;
            r_inv_d2  <= v_dout[7];
        end
    end

    // ~x equals 7-x for a 3-bit column: bit 7 is the leftmost pixel.
    assign w_pix = font_data[~r_hcnt_d2] ^ r_inv_d2;

    // ------------------------------------------------------------------
    // Stage 3: registered panel outputs
    // ------------------------------------------------------------------
    logic r_pix_d3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_d3 <= 1'b0;
        end else begin
            r_pix_d3 <= r_ctl_pipe[2][0] & w_pix;
        end
    end

    assign lcd_de    = r_ctl_pipe[3][0];
    assign lcd_hsync = ~r_ctl_pipe[3][1];
    assign lcd_vsync = ~r_ctl_pipe[3][2];
    assign lcd_r     = {5{r_pix_d3}};
    assign lcd_g     = {6{r_pix_d3}};
    assign lcd_b     = {5{r_pix_d3}};

endmodule

// File: tb/tb_lcd_text_reader.sv
// Directed bench for lcd_text_reader on a shrunken raster so a full frame
// (and more) fits in a short run:
//   H: 32 visible + 2 fp + 5 sync + 2 bp = 41 clocks per line
//   V: 32 visible + 2 fp + 3 sync + 2 bp = 39 lines per frame (1599 clocks)
//   COLS = 4 -> two text rows of four cells, highest address 1*4+3 = 7
// Edge k = k-th rising edge after reset release; in the cycle after edge k the
// raster position is hcnt = k mod 41, vcnt = k div 41 (first frame). A pixel
// fetched in the cycle after edge k appears on the outputs after edge k+3.

module tb_lcd_text_reader;

    localparam int H_ACTIVE = 32;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 5;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 32;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 2;
    localparam int COLS     = 4;

    localparam int WHITE = 65535;
    localparam int BLACK = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  v_adb;
    logic        v_ceb;
    logic [7:0]  v_dout = 8'h00;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic        lcd_de;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic        frame_start;

    always #5 clk = ~clk;

    lcd_text_reader #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COLS(COLS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .v_adb       (v_adb),
        .v_ceb       (v_ceb),
        .v_dout      (v_dout),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .lcd_de      (lcd_de),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_r       (lcd_r),
        .lcd_g       (lcd_g),
        .lcd_b       (lcd_b),
        .frame_start (frame_start)
    );

    // VRAM model: synchronous read, one clock latency.
    logic [7:0] vram [0:1023];
    always @(posedge clk) begin
        if (v_ceb) v_dout <= vram[v_adb];
    end

    // Font model: glyph 'A' (0x41) row 0 is 0x80, every other row/char blank.
    always @(posedge clk) begin
        font_data <= (font_addr == 11'h410) ? 8'h80 : 8'h00;
    end

    int n_total = 0;
    int n_bad   = 0;
    int edge_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic run_to(input int k);
        while (edge_cnt < k) step();
    endtask

    function automatic int rgb();
        return int'({lcd_r, lcd_g, lcd_b});
    endfunction

    initial begin
        int de_total, de_rises, de_line0, hs_low, vs_low, fs_cnt;
        int hs_fall0, hs_fall1, vs_fall, vs_rise;
        logic prev_de, prev_hs, prev_vs;

        for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
        vram[0] = 8'h41;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_de",     int'(lcd_de), 0);
        check("rst_hsync",  int'(lcd_hsync), 1);
        check("rst_vsync",  int'(lcd_vsync), 1);
        check("rst_rgb",    rgb(), 0);
        check("rst_ceb",    int'(v_ceb), 0);
        check("rst_adb",    int'(v_adb), 0);
        check("rst_faddr",  int'(font_addr), 0);
        check("rst_fstart", int'(frame_start), 0);

        @(negedge clk);
        rst_n = 1'b1;
        edge_cnt = 0;
        #1;
        check("rel_ceb0", int'(v_ceb), 1);
        check("rel_adb0", int'(v_adb), 0);

        step();  // edge 1
        check("e1_de",    int'(lcd_de), 0);
        check("e1_faddr", int'(font_addr), 11'h410);
        step();  // edge 2
        check("e2_de",    int'(lcd_de), 0);

        // ---------------- one full frame, edges 3..1601 ----------------
        de_total = 0; de_rises = 0; de_line0 = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
        hs_fall0 = -1; hs_fall1 = -1; vs_fall = -1; vs_rise = -1;
        prev_de = lcd_de; prev_hs = lcd_hsync; prev_vs = lcd_vsync;
        for (int k = 3; k <= 1601; k++) begin
            step();
            if (k == 3) begin
                check("e3_de", int'(lcd_de), 1);
                check("px0_white", rgb(), WHITE);
            end
            if (k >= 4 && k <= 10) check($sformatf("px%0d_black", k - 3), rgb(), BLACK);
            if (k == 11) check("px8_black", rgb(), BLACK);
            if (k == 44) check("px0_row1_black", rgb(), BLACK);
            if (k == 664) begin
                check("adb_h8_v16", int'(v_adb), 5);
                check("ceb_h8_v16", int'(v_ceb), 1);
            end
            if (k == 1302) check("adb_max", int'(v_adb), 7);
            if (k == 1303) begin
                check("ceb_h32", int'(v_ceb), 0);
                check("adb_hold", int'(v_adb), 7);
            end
            if (k == 1311) check("fs_before", int'(frame_start), 0);
            if (k == 1312) check("fs_at",     int'(frame_start), 1);
            if (k == 1313) check("fs_after",  int'(frame_start), 0);
            if (k == 1500) vram[0] = 8'hC1;

            if (lcd_de) de_total++;
            if (lcd_de && !prev_de) de_rises++;
            if (lcd_de && k <= 43) de_line0++;
            if (!lcd_hsync) hs_low++;
            if (!lcd_vsync) vs_low++;
            if (frame_start) fs_cnt++;
            if (!lcd_hsync && prev_hs) begin
                if (hs_fall0 < 0) hs_fall0 = k;
                else if (hs_fall1 < 0) hs_fall1 = k;
            end
            if (!lcd_vsync && prev_vs && vs_fall < 0) vs_fall = k;
            if (lcd_vsync && !prev_vs && vs_rise < 0) vs_rise = k;
            prev_de = lcd_de; prev_hs = lcd_hsync; prev_vs = lcd_vsync;
        end
        check("de_line0",     de_line0, 32);
        check("de_frame",     de_total, 32 * 32);
        check("de_lines",     de_rises, 32);
        check("hs_low_frame", hs_low, 5 * 39);
        check("hs_fall0",     hs_fall0, 37);
        check("hs_period",    hs_fall1 - hs_fall0, 41);
        check("vs_low_frame", vs_low, 3 * 41);
        check("vs_fall",      vs_fall, 1397);
        check("vs_rise",      vs_rise, 1520);
        check("fs_per_frame", fs_cnt, 1);

        // ---------------- inverse video, second frame ----------------
        run_to(1602);
        check("inv_px0_black", rgb(), BLACK);
        for (int k = 1603; k <= 1609; k++) begin
            run_to(k);
            check($sformatf("inv_px%0d_white", k - 1602), rgb(), WHITE);
        end
        run_to(1610);
        check("inv_px8_black", rgb(), BLACK);

        run_to(2910);
        check("fs2_before", int'(frame_start), 0);
        run_to(2911);
        check("fs2_at", int'(frame_start), 1);

        // ---------------- mid-line reset ----------------
        run_to(3418);  // hcnt=15, vcnt=5 of frame 2
        check("pre_rst_de", int'(lcd_de), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_de",    int'(lcd_de), 0);
        check("mrst_hsync", int'(lcd_hsync), 1);
        check("mrst_vsync", int'(lcd_vsync), 1);
        check("mrst_rgb",   rgb(), 0);
        check("mrst_ceb",   int'(v_ceb), 0);
        check("mrst_adb",   int'(v_adb), 0);
        check("mrst_faddr", int'(font_addr), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edge_cnt = 0;
        #1;
        check("mrel_ceb0", int'(v_ceb), 1);
        check("mrel_adb0", int'(v_adb), 0);
        step();
        check("mrel_e1_de",  int'(lcd_de), 0);
        check("mrel_e1_rgb", rgb(), 0);
        step();
        check("mrel_e2_de",  int'(lcd_de), 0);
        check("mrel_e2_rgb", rgb(), 0);
        step();
        check("mrel_e3_de",  int'(lcd_de), 1);
        check("mrel_px0_black", rgb(), BLACK);
        step();
        check("mrel_px1_white", rgb(), WHITE);
        run_to(8);
        check("mrel_adb_h8", int'(v_adb), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_text_reader.md
LCD_TEXT_READER -- requirements
Module: lcd_text_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 2, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 41, hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 2, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 272, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 2, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 10, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 2, vertical back porch in lines.
REQ-009 SHALL have parameter COLS, default 60, text columns per row (VRAM row stride).
REQ-010 SHALL have ports, in order: clk in 1 (single clock); rst_n in 1 (asynchronous, active-low reset).
REQ-011 SHALL have ports: v_adb out 10 (VRAM read address); v_ceb out 1 (VRAM read enable); v_dout in 8 (VRAM read data).
REQ-012 SHALL have ports: font_addr out 11 ({char[6:0], glyph_row[3:0]}); font_data in 8 (glyph row, bit 7 = leftmost pixel).
REQ-013 SHALL have ports: lcd_de out 1; lcd_hsync out 1 (active-low); lcd_vsync out 1 (active-low); lcd_r out 5; lcd_g out 6; lcd_b out 5; frame_start out 1 (one-clock pulse).

Function
REQ-014 SHALL keep hcnt running 0..H_ACTIVE+H_FP+H_SYNC+H_BP-1 (default 0..524), then wrap to 0.
REQ-015 SHALL keep vcnt running 0..V_ACTIVE+V_FP+V_SYNC+V_BP-1 (default 0..285), incrementing only when hcnt wraps, then wrapping to 0.
REQ-016 SHALL define stage-0 active as hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-017 SHALL define hsync_raw low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; vsync_raw likewise on vcnt.
REQ-018 SHALL, in stage 0 when active, drive v_ceb=1 and v_adb=(vcnt>>4)*COLS+(hcnt>>3); otherwise v_ceb=0 and v_adb holds its last value.
REQ-019 SHALL treat v_dout as valid exactly one clock after the address (stage 1).
REQ-020 SHALL, in stage 1, drive font_addr={v_dout[6:0], vcnt_d1[3:0]} and register v_dout[7] as the invert flag.
REQ-021 SHALL treat font_data as valid one clock after font_addr (stage 2).
REQ-022 SHALL, in stage 2, select pixel bit = font_data[7-hcnt_d2[2:0]] XOR invert_d1.
REQ-023 SHALL register outputs at stage 3: pixel 1 gives r/g/b all ones; pixel 0 or not active gives all zeros.
REQ-024 SHALL delay active, hsync_raw and vsync_raw by 3 clocks so lcd_de/lcd_hsync/lcd_vsync align with pixel data; total latency is 3 clocks.
REQ-025 SHALL pulse frame_start for one clock on the stage-0 cycle where hcnt=0 and vcnt=V_ACTIVE (start of vertical blanking).
REQ-026 SHALL never issue a VRAM address above 1019 with defaults; the maximum is row 16 * 60 + column 59.
REQ-027 SHALL compute the address with no truncation: row*COLS computed in 10 bits, with the sum width-checked against 10 bits.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force hcnt=0, vcnt=0, all pipeline registers=0, v_ceb=0, v_adb=0, font_addr=0, lcd_de=0, lcd_r/g/b=0, frame_start=0, lcd_hsync=1, lcd_vsync=1.
REQ-029 SHALL, after rst_n deasserts mid-frame, restart timing at hcnt=0, vcnt=0 on the first rising edge with no stale pipeline pixels emitted.

Verification
REQ-030 SHALL be checked: reset release -> first lcd_de rise 3 clocks after the first clock edge; lcd_de high for 480 clocks per line, 272 lines per frame.
REQ-031 SHALL be checked: period measurement -> hsync low 41 clocks every 525; vsync low 10 lines every 286 lines; frame_start once per 150150 clocks.
REQ-032 SHALL be checked: VRAM address sweep -> at hcnt=8, vcnt=16 v_adb=61; at hcnt=479, vcnt=271 v_adb=1019; v_ceb=0 at hcnt=480.
REQ-033 SHALL be checked: VRAM cell 0 = 0x41 and font model returning 0x80 for row 0 -> pixel (0,0) white, pixels (1..7,0) black.
REQ-034 SHALL be checked: cell 0 = 0xC1 with the same font -> pixel (0,0) black, pixels (1..7,0) white (inverse video).
REQ-035 SHALL be checked: rst_n pulsed low mid-line -> outputs reach reset values immediately, and timing resumes from hcnt=0, vcnt=0.
